// File: rtl/turbo_qpp_interleaver.sv
// Ping-pong QPP block interleaver feeding the second RSC encoder, with trellis-termination framing.
// Optional feature macro INTLV_BYPASS_EN adds a 'bypass' input selecting natural (non-permuted) order.
module turbo_qpp_interleaver #(
  parameter int K  = 40,
  parameter int F1 = 3,
  parameter int F2 = 10,
  parameter int AW = 6
) (
  input  logic clk,
  input  logic rst_N,
`ifdef INTLV_BYPASS_EN
  input  logic bypass,
`endif
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  output logic out_bit,
  output logic out_mode,
  output logic out_rst_N
);

  localparam logic [AW-1:0] G0   = AW'((F1 + F2) % K);
  localparam logic [AW-1:0] S0   = AW'((2 * F2) % K);
  localparam logic [AW-1:0] LAST = AW'(K - 1);
  localparam logic [AW:0]   KW   = (AW+1)'(K);
  localparam logic [AW:0]   TLAST = (AW+1)'(3);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  state_t        state, state_nxt;
  logic [K-1:0]  bank [2];
  logic [1:0]    full;
  logic          wsel, rsel, ready_en;
  logic [AW-1:0] wptr, p, g, s;
  logic [AW-1:0] g_init, s_init;
  logic [AW:0]   cnt;
  logic          wr_fire, wr_last, start, data_more, release_bank;
  logic          bit_nxt, mode_nxt, act_nxt;

  // Both operands are already below K, so one conditional subtract reduces the sum.
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= KW) sum = sum - KW;
    return sum[AW-1:0];
  endfunction

  assign in_ready     = ready_en & ~full[wsel];
  assign wr_fire      = in_valid & in_ready;
  assign wr_last      = wr_fire & (wptr == LAST);
  assign start        = (state == IDLE) & full[rsel];
  assign data_more    = cnt < KW;
  assign release_bank = (state == TAIL) & (cnt == TLAST);

`ifdef INTLV_BYPASS_EN
  assign g_init = bypass ? AW'(1) : G0;
  assign s_init = bypass ? '0 : S0;
`else
  assign g_init = G0;
  assign s_init = S0;
`endif

  always_ff @(posedge clk) begin
    if (rst_N && wr_fire) bank[wsel][wptr] <= in_bit;
  end

  // Read and write always sit on different banks, so the two flag updates never collide.
  always_ff @(posedge clk) begin
    if (!rst_N) begin
      full     <= '0;
      wsel     <= 1'b0;
      rsel     <= 1'b0;
      wptr     <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (wr_fire) wptr <= wr_last ? '0 : wptr + AW'(1);
      if (wr_last) begin
        full[wsel] <= 1'b1;
        wsel       <= ~wsel;
      end
      if (release_bank) begin
        full[rsel] <= 1'b0;
        rsel       <= ~rsel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (full[rsel]) state_nxt = DATA;
      DATA:    if (!data_more) state_nxt = TAIL;
      TAIL:    if (cnt == TLAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next registered output; p/g always hold the address of the bit to emit next.
  always_comb begin
    bit_nxt  = 1'b0;
    mode_nxt = 1'b0;
    act_nxt  = 1'b0;
    case (state)
      IDLE: if (start) begin
        bit_nxt = bank[rsel][0];
        act_nxt = 1'b1;
      end
      DATA: begin
        act_nxt = 1'b1;
        if (data_more) bit_nxt = bank[rsel][p];
      end
      TAIL: if (cnt != TLAST) begin
        act_nxt  = 1'b1;
        mode_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Second-order recurrence: p steps by g, g steps by s, replacing the quadratic product.
  always_ff @(posedge clk) begin
    if (!rst_N) begin
      p   <= '0;
      g   <= '0;
      s   <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          p   <= g_init;
          g   <= mod_add(g_init, s_init);
          s   <= s_init;
          cnt <= (AW+1)'(1);
        end
        DATA: if (data_more) begin
          p   <= mod_add(p, g);
          g   <= mod_add(g, s);
          cnt <= cnt + (AW+1)'(1);
        end else begin
          cnt <= '0;
        end
        TAIL:    cnt <= (cnt == TLAST) ? '0 : cnt + (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_N) begin
      out_bit   <= 1'b0;
      out_mode  <= 1'b0;
      out_rst_N <= 1'b0;
    end else begin
      out_bit   <= bit_nxt;
      out_mode  <= mode_nxt;
      out_rst_N <= act_nxt;
    end
  end

endmodule

// File: tb/tb_turbo_qpp_interleaver.sv
// tb_turbo_qpp_interleaver: every accepted K-bit block is permuted by a reference model into a
// scoreboard queue; a monitor checks the encoder-side stream and its framing against it.
`timescale 1ns/1ps
module tb_turbo_qpp_interleaver;
  localparam int K = 40, F1 = 3, F2 = 10, AW = 6;

  logic clk = 1'b0, rst_N = 1'b0, in_bit = 1'b0, in_valid = 1'b0;
  logic in_ready, out_bit, out_mode, out_rst_N;
`ifdef INTLV_BYPASS_EN
  logic bypass = 1'b0;
`endif

  int   errors = 0, checks = 0;
  logic exp_q[$];
  logic cur_blk[$];
  int   run = 0, blocks_done = 0, ones = 0, last_one = -1;
  bit   aborted = 1'b0;

  turbo_qpp_interleaver #(.K(K), .F1(F1), .F2(F2), .AW(AW)) dut (
    .clk(clk),
    .rst_N(rst_N),
`ifdef INTLV_BYPASS_EN
    .bypass(bypass),
`endif
    .in_bit(in_bit),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_bit(out_bit),
    .out_mode(out_mode),
    .out_rst_N(out_rst_N)
  );

  always #5 clk = ~clk;

  task automatic failNow(input string name, input int actual, input int required);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, required, $time);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  // Reference: output position j of a block carries natural input bit (F1*j + F2*j*j) mod K.
  function automatic void modelAccept(input logic b);
    cur_blk.push_back(b);
    if (cur_blk.size() == K) begin
      for (int j = 0; j < K; j++) exp_q.push_back(cur_blk[(F1 * j + F2 * j * j) % K]);
      cur_blk.delete();
    end
  endfunction

  // Monitor: pops the scoreboard on data cycles and checks the tail/framing rules.
  always @(negedge clk) begin
    if (out_rst_N === 1'b1) begin
      if (run == 0) begin
        ones     = 0;
        last_one = -1;
      end
      if (run < K) begin
        if (exp_q.size() == 0) failNow("data_underflow", exp_q.size(), 1);
        else checkOutput("data_bit", out_bit, exp_q.pop_front());
        checkOutput("data_mode", out_mode, 0);
        if (out_bit === 1'b1) begin
          ones++;
          last_one = run;
        end
      end else if (run < K + 4) begin
        checkOutput("tail_bit", out_bit, 0);
        checkOutput("tail_mode", out_mode, (run >= K + 1) ? 1 : 0);
      end else begin
        failNow("window_overrun", run + 1, K + 4);
      end
      run++;
    end else begin
      if (run != 0) begin
        if (!aborted) begin
          checkOutput("window_len", run, K + 4);
          blocks_done++;
        end
        checkOutput("idle_bit", out_bit, 0);
        checkOutput("idle_mode", out_mode, 0);
      end
      run = 0;
    end
  end

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic b, input int budget);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk); #1;
      in_valid = 1'b1;
      in_bit   = b;
      if (in_ready === 1'b1) begin
        modelAccept(b);
        done = 1'b1;
      end else if (++n > budget) begin
        failNow("accept_timeout", n, budget);
        done = 1'b1;
      end
    end
  endtask

  task automatic sendBlock(input logic [K-1:0] v, input int gap_max);
    for (int i = 0; i < K; i++) begin
      if (gap_max > 0) idleCycles($urandom_range(gap_max, 0));
      applyStimulus(v[i], 400);
    end
    idleCycles(1);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || run != 0) && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    if (n >= budget) failNow("drain_timeout", n, budget);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pos_tab[4];
    int exp_tab[4];
    logic [K-1:0] v;
    logic [63:0]  r;
    int acc, first_stall, guard, b0;

    pos_tab = '{13, 19, 6, 0};
    exp_tab = '{1, 3, 2, 0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_out_bit", out_bit, 0);
    checkOutput("rst_out_mode", out_mode, 0);
    checkOutput("rst_out_rst_N", out_rst_N, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    rst_N = 1'b1;
    @(negedge clk); #1;
    checkOutput("ready_after_rst", in_ready, 1);

    // Single-one blocks; the first also checks start latency
    for (int k = 0; k < 4; k++) begin
      v = '0;
      v[pos_tab[k]] = 1'b1;
      sendBlock(v, 0);
      if (k == 0) begin
        checkOutput("latency_idle", out_rst_N, 0);
        @(negedge clk); #1;
        checkOutput("latency_first", out_rst_N, 1);
      end
      waitDrain(500);
      checkOutput("one_count", ones, 1);
      checkOutput("one_pos", last_one, exp_tab[k]);
    end

    // Parity pattern
    for (int i = 0; i < K; i++) v[i] = ($countones(i) % 2) == 1;
    sendBlock(v, 0);
    waitDrain(500);

    // Random blocks with random input gaps
    for (int k = 0; k < 3; k++) begin
      r = {$urandom(), $urandom()};
      v = r[K-1:0];
      sendBlock(v, 3);
    end
    waitDrain(2000);

    // Backpressure: continuous valid for 200 bits
    b0          = blocks_done;
    acc         = 0;
    first_stall = -1;
    guard       = 0;
    while (acc < 200 && guard < 3000) begin
      @(negedge clk); #1;
      in_valid = 1'b1;
      in_bit   = $urandom_range(1, 0);
      if (in_ready === 1'b1) begin
        modelAccept(in_bit);
        acc++;
      end else if (first_stall < 0) begin
        first_stall = acc;
      end
      guard++;
    end
    idleCycles(1);
    checkOutput("bp_accepted", acc, 200);
    checkOutput("bp_stall_point", first_stall, 80);
    waitDrain(3000);
    checkOutput("bp_blocks", blocks_done - b0, 5);

    // Reset in the middle of DATA
    r = {$urandom(), $urandom()};
    v = r[K-1:0];
    sendBlock(v, 0);
    guard = 0;
    while (run != 21 && guard < 500) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 500) failNow("mid_reset_wait", guard, 500);
    rst_N   = 1'b0;
    aborted = 1'b1;
    exp_q.delete();
    cur_blk.delete();
    @(negedge clk); #1;
    checkOutput("abort_out_rst_N", out_rst_N, 0);
    checkOutput("abort_out_bit", out_bit, 0);
    checkOutput("abort_out_mode", out_mode, 0);
    checkOutput("abort_in_ready", in_ready, 0);
    rst_N   = 1'b1;
    aborted = 1'b0;
    @(negedge clk); #1;
    checkOutput("abort_ready_back", in_ready, 1);

    // Fresh block after abort must not see stale data
    b0 = blocks_done;
    for (int i = 0; i < K; i++) v[i] = ($countones(i) % 2) == 0;
    sendBlock(v, 1);
    waitDrain(500);
    checkOutput("fresh_block", blocks_done - b0, 1);

    idleCycles(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
